// File: rtl/ddr3_cmd_responder.sv
// DDR3-side end of the memoryController command handshake: latches one 128-bit read or write,
// acknowledges it, drives the MIG native app interface and returns data plus a completion pulse.
module ddr3_cmd_responder #(
    parameter int ADDR_W         = 27,
    parameter int DATA_W         = 128,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   alexAddress,
    input  logic [DATA_W-1:0]   alexWriteData,
    input  logic [DATA_W/16-1:0] alexWriteBytes,
    input  logic [1:0]          alexMemEnable,
    input  logic                alexNewCommand,
    output logic                alexCommandAcknowledged,
    output logic                alexFinishedMemAction,
    output logic [DATA_W-1:0]   alexReadData,
    output logic [3:0]          alexMemReady,
    input  logic                init_calib_complete,
    output logic [ADDR_W-1:0]   app_addr,
    output logic [2:0]          app_cmd,
    output logic                app_en,
    input  logic                app_rdy,
    output logic [DATA_W-1:0]   app_wdf_data,
    output logic [DATA_W/8-1:0] app_wdf_mask,
    output logic                app_wdf_wren,
    output logic                app_wdf_end,
    input  logic                app_wdf_rdy,
    input  logic [DATA_W-1:0]   app_rd_data,
    input  logic                app_rd_data_valid
);

    localparam int HW_N   = DATA_W / 16;
    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_WR_ISSUE,
        S_DONE,
        S_WAIT_LOW
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                cmd_done_q, cmd_done_d;
    logic                wr_done_q, wr_done_d;
    logic                timeout_err_q, timeout_err_d;
    logic                ack_q, ack_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   mask_q, mask_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [MASK_W-1:0]   new_mask;
    logic                cmd_valid;

    assign cmd_valid = init_calib_complete && alexNewCommand &&
                       (alexMemEnable == 2'b01 || alexMemEnable == 2'b10);

    // NOTE: every signal written in a combinational block gets a default first, so no path
    // through the case/if tree leaves it unassigned and a latch can never be inferred.
    always_comb begin
        new_mask = '0;
        for (int i = 0; i < HW_N; i++) begin
            new_mask[2*i +: 2] = {2{~alexWriteBytes[i]}};
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cmd_done_d    = cmd_done_q;
        wr_done_d     = wr_done_q;
        timeout_err_d = timeout_err_q;
        ack_d         = 1'b0;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        mask_d        = mask_q;
        rdata_d       = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d     = {alexAddress[ADDR_W-1:3], 3'b000};
                    wdata_d    = alexWriteData;
                    mask_d     = new_mask;
                    ack_d      = 1'b1;
                    cmd_done_d = 1'b0;
                    wr_done_d  = 1'b0;
                    state_d    = (alexMemEnable == 2'b01) ? S_RD_ISSUE : S_WR_ISSUE;
                end
            end
            S_RD_ISSUE: begin
                cnt_d = '0;
                if (app_rdy) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                // Data arriving on the last allowed cycle still wins over the timeout.
                if (app_rd_data_valid) begin
                    rdata_d = app_rd_data;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WR_ISSUE: begin
                // Command and data channels complete independently, in either order.
                if (app_rdy)     cmd_done_d = 1'b1;
                if (app_wdf_rdy) wr_done_d  = 1'b1;
                if (cmd_done_d && wr_done_d) state_d = S_DONE;
            end
            S_DONE:     state_d = S_WAIT_LOW;
            S_WAIT_LOW: if (!alexNewCommand) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together
    // from values sampled before the edge, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            cmd_done_q    <= 1'b0;
            wr_done_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            ack_q         <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            mask_q        <= '0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_done_q    <= cmd_done_d;
            wr_done_q     <= wr_done_d;
            timeout_err_q <= timeout_err_d;
            ack_q         <= ack_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            mask_q        <= mask_d;
            rdata_q       <= rdata_d;
        end
    end

    assign alexCommandAcknowledged = ack_q;
    assign alexFinishedMemAction   = (state_q == S_DONE);
    assign alexReadData            = rdata_q;
    assign app_addr                = addr_q;
    assign app_wdf_data            = wdata_q;
    assign app_wdf_mask            = mask_q;
    assign app_en   = (state_q == S_RD_ISSUE) || (state_q == S_WR_ISSUE && !cmd_done_q);
    assign app_cmd  = (state_q == S_RD_ISSUE) ? 3'b001 : 3'b000;
    assign app_wdf_wren = (state_q == S_WR_ISSUE) && !wr_done_q;
    assign app_wdf_end  = app_wdf_wren;

    // Status is forced low while reset is held so that every output reads 0 during reset.
    assign alexMemReady = reset ? 4'b0000 :
                          {timeout_err_q, state_q != S_IDLE, init_calib_complete, state_q == S_IDLE};

endmodule

// File: tb/tb_ddr3_cmd_responder.sv
// Self-checking bench for ddr3_cmd_responder: directed and randomized commands checked
// cycle by cycle against a protocol-level timing model of the command handshake.
module tb_ddr3_cmd_responder;

    localparam int ADDR_W = 27;
    localparam int DATA_W = 128;
    localparam int TMO    = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic [ADDR_W-1:0]   alexAddress;
    logic [DATA_W-1:0]   alexWriteData;
    logic [7:0]          alexWriteBytes;
    logic [1:0]          alexMemEnable;
    logic                alexNewCommand;
    logic                alexCommandAcknowledged;
    logic                alexFinishedMemAction;
    logic [DATA_W-1:0]   alexReadData;
    logic [3:0]          alexMemReady;
    logic                calib;
    logic [ADDR_W-1:0]   app_addr;
    logic [2:0]          app_cmd;
    logic                app_en;
    logic                app_rdy;
    logic [DATA_W-1:0]   app_wdf_data;
    logic [15:0]         app_wdf_mask;
    logic                app_wdf_wren;
    logic                app_wdf_end;
    logic                app_wdf_rdy;
    logic [DATA_W-1:0]   app_rd_data;
    logic                app_rd_data_valid;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [DATA_W-1:0] exp_rdata = '0;
    logic              exp_terr  = 1'b0;

    always #5 clk = ~clk;

    ddr3_cmd_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .alexAddress(alexAddress), .alexWriteData(alexWriteData),
        .alexWriteBytes(alexWriteBytes), .alexMemEnable(alexMemEnable),
        .alexNewCommand(alexNewCommand),
        .alexCommandAcknowledged(alexCommandAcknowledged),
        .alexFinishedMemAction(alexFinishedMemAction),
        .alexReadData(alexReadData), .alexMemReady(alexMemReady),
        .init_calib_complete(calib),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
    );

    wire [310:0] all_out = {alexCommandAcknowledged, alexFinishedMemAction, alexReadData,
                            alexMemReady, app_addr, app_cmd, app_en, app_wdf_data,
                            app_wdf_mask, app_wdf_wren, app_wdf_end};
    wire [11:0] ctl_obs = {alexCommandAcknowledged, app_en, app_cmd, app_wdf_wren, app_wdf_end,
                           alexFinishedMemAction, alexMemReady};

    task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Presents one command and checks every cycle until the responder is idle again.
    // ra/wa: cycles (from the ack cycle) before app_rdy/app_wdf_rdy rise; vd: RD_WAIT cycles
    // before read data (>= TMO means never); hold: extra cycles the command level stays high.
    task automatic run_cmd(input logic [1:0] en, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data, input logic [7:0] bytes,
                           input int ra, input int wa, input int vd, input int hold,
                           input bit spur);
        bit acc, rd, to, t_before;
        int fin, keep_until, idle_c, last, vc;
        logic [15:0] m;
        logic [11:0] e;
        acc      = calib && (en == 2'b01 || en == 2'b10);
        rd       = (en == 2'b01);
        to       = rd && (vd >= TMO);
        t_before = exp_terr;
        if (!acc)    fin = -1;
        else if (rd) fin = to ? ra + 1 + TMO : ra + 2 + vd;
        else         fin = ((ra > wa) ? ra : wa) + 1;
        keep_until = acc ? fin + hold : hold;
        idle_c     = acc ? ((fin + 2 > keep_until + 1) ? fin + 2 : keep_until + 1) : 0;
        last       = acc ? idle_c : keep_until + 1;
        vc         = ra + 1 + vd;
        for (int i = 0; i < 8; i++) m[2*i +: 2] = bytes[i] ? 2'b00 : 2'b11;

        alexNewCommand = 1'b1;
        alexMemEnable  = en;
        alexAddress    = addr;
        alexWriteData  = data;
        alexWriteBytes = bytes;
        tick();
        for (int c = 0; c <= last; c++) begin
            e[11]  = acc && c == 0;
            e[10]  = acc && c <= ra;
            e[9:7] = (acc && rd && c <= ra) ? 3'b001 : 3'b000;
            e[6]   = acc && !rd && c <= wa;
            e[5]   = e[6];
            e[4]   = acc && c == fin;
            e[3]   = (acc && to && c >= fin) ? 1'b1 : t_before;
            e[2]   = acc && c < idle_c;
            e[1]   = calib;
            e[0]   = !e[2];
            check($sformatf("ctl en=%b c=%0d", en, c), ctl_obs, e);
            if (acc && c == 0) begin
                check("app_addr", app_addr, {addr[ADDR_W-1:3], 3'b000});
                if (!rd) begin
                    check("app_wdf_data", app_wdf_data, data);
                    check("app_wdf_mask", app_wdf_mask, m);
                end
            end
            if (acc && rd && (c == fin || c == fin + 1))
                check($sformatf("read_data c=%0d", c), alexReadData, to ? exp_rdata : data);

            alexNewCommand    = (c < keep_until);
            app_rdy           = (c >= ra);
            app_wdf_rdy       = (c >= wa);
            app_rd_data_valid = 1'b0;
            app_rd_data       = '0;
            if (acc && rd && !to && c == vc) begin
                app_rd_data_valid = 1'b1;
                app_rd_data       = data;
            end else if ((spur && c == 0) || (acc && to && c == fin)) begin
                app_rd_data_valid = 1'b1;
                app_rd_data       = ~data;
            end
            tick();
        end
        app_rdy           = 1'b0;
        app_wdf_rdy       = 1'b0;
        app_rd_data_valid = 1'b0;
        if (acc && rd && !to) exp_rdata = data;
        if (acc && to) exp_terr = 1'b1;
    endtask

    function automatic logic [DATA_W-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        reset = 1'b1; calib = 1'b0;
        alexAddress = '0; alexWriteData = '0; alexWriteBytes = '0; alexMemEnable = '0;
        alexNewCommand = 1'b0; app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        app_rd_data = '0; app_rd_data_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_out, '0);
        reset = 1'b0;
        tick();
        check("post_reset_ready", alexMemReady, 4'b0001);

        calib = 1'b1;
        run_cmd(2'b01, 27'h0000123, 128'hDEAD0000_11112222_33334444_0000BEEF, 8'hFF,
                0, 0, 9, 0, 1'b1);
        run_cmd(2'b10, 27'($urandom), rand_word(), 8'b0000_0001, 5, 0, 0, 0, 1'b0);
        run_cmd(2'b01, 27'($urandom), rand_word(), 8'h00, 1, 0, 3, 50, 1'b0);
        run_cmd(2'b11, 27'($urandom), rand_word(), 8'h00, 0, 0, 0, 5, 1'b0);
        run_cmd(2'b00, 27'($urandom), rand_word(), 8'h00, 0, 0, 0, 3, 1'b0);
        calib = 1'b0;
        run_cmd(2'b01, 27'($urandom), rand_word(), 8'h00, 0, 0, 0, 5, 1'b0);
        calib = 1'b1;
        run_cmd(2'b01, 27'($urandom), rand_word(), 8'h00, 2, 0, TMO - 1, 0, 1'b1);
        run_cmd(2'b10, 27'($urandom), rand_word(), 8'hA5, 3, 0, 0, 0, 1'b1);
        run_cmd(2'b10, 27'($urandom), rand_word(), 8'h5A, 0, 4, 0, 0, 1'b0);
        run_cmd(2'b10, 27'($urandom), rand_word(), 8'($urandom), 2, 2, 0, 2, 1'b0);
        for (int k = 0; k < 20; k++)
            run_cmd($urandom_range(0, 1) ? 2'b01 : 2'b10, 27'($urandom), rand_word(),
                    8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, TMO - 2), $urandom_range(0, 2), 1'($urandom));

        run_cmd(2'b01, 27'($urandom), rand_word(), 8'h00, 1, 0, TMO, 0, 1'b0);
        run_cmd(2'b01, 27'($urandom), rand_word(), 8'h00, 0, 0, 4, 0, 1'b0);

        // Reset in the middle of a read wait abandons it; stray read data afterwards is ignored.
        alexNewCommand = 1'b1; alexMemEnable = 2'b01; alexAddress = 27'($urandom);
        app_rdy = 1'b1;
        tick();
        alexNewCommand = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        #1;
        check("reset_mid_read", all_out, '0);
        exp_rdata = '0; exp_terr = 1'b0;
        app_rd_data = rand_word(); app_rd_data_valid = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("after_reset c=%0d", c), ctl_obs, 12'b0000_0000_0011);
            check($sformatf("after_reset_data c=%0d", c), alexReadData, exp_rdata);
        end
        app_rd_data_valid = 1'b0; app_rdy = 1'b0;
        run_cmd(2'b01, 27'($urandom), rand_word(), 8'h00, 0, 0, 2, 0, 1'b0);
        run_cmd(2'b10, 27'($urandom), rand_word(), 8'hF0, 1, 1, 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
